// File: rtl/ct_wb_burst_master.sv
// Wishbone B3 burst initiator for the compute tile bus.
// It takes one command at a time and runs it as either a classic single
// cycle or an incrementing burst (linear or wrapping) with registered
// feedback. Write data comes from a valid/ready stream. Read data leaves as
// a registered one-cycle valid stream.
module ct_wb_burst_master #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int lw = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  // command channel
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [aw-1:0]   cmd_adr_i,
  input  logic [lw-1:0]   cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  // write data stream
  input  logic            wdat_valid_i,
  input  logic [dw-1:0]   wdat_i,
  output logic            wdat_ready_o,
  // read data stream
  output logic            rdat_valid_o,
  output logic [dw-1:0]   rdat_o,
  // completion
  output logic            done_o,
  output logic            done_err_o,
  // Wishbone master
  output logic [aw-1:0]   wb_adr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic            classic_q;
  logic [aw-3:0]   word_q;
  logic [lw-1:0]   cnt_q;
  logic [1:0]      bte_q;
  logic            done_q, done_err_q;
  logic            rdat_valid_q;
  logic [dw-1:0]   rdat_q;

  logic            accept;
  logic            beat_ok;
  logic            last_beat;
  logic            abort;

  // Tile slaves tie rty low. The two low address bits only select bytes.
  logic unused_ok;
  assign unused_ok = ^{wb_rty_i, cmd_adr_i[1:0]};

  // Compute the next word address. Wrapping bursts increment only the low
  // log2(N) bits and keep the upper bits.
  function automatic logic [aw-3:0] next_word(input logic [aw-3:0] w,
                                              input logic [1:0]    bte);
    logic [aw-3:0] inc;
    inc = w + (aw-2)'(1);
    case (bte)
      2'b01:   return {w[aw-3:2], inc[1:0]};
      2'b10:   return {w[aw-3:3], inc[2:0]};
      2'b11:   return {w[aw-3:4], inc[3:0]};
      default: return inc;
    endcase
  endfunction

  assign cmd_ready_o  = (state_q == IDLE);
  assign accept       = cmd_valid_i & cmd_ready_o;

  assign wb_cyc_o     = (state_q == BUS);
  assign wb_stb_o     = wb_cyc_o & (~we_q | wdat_valid_i);
  assign wb_we_o      = wb_cyc_o & we_q;
  assign wb_adr_o     = {word_q, 2'b00};
  assign wb_dat_o     = wdat_i;
  assign wb_sel_o     = '1;
  assign wb_bte_o     = wb_cyc_o ? bte_q : 2'b00;
  assign wb_cti_o     = (!wb_cyc_o || classic_q) ? 3'b000 :
                        (cnt_q == '0)            ? 3'b111 : 3'b010;

  assign wdat_ready_o = beat_ok & we_q;
  assign rdat_valid_o = rdat_valid_q;
  assign rdat_o       = rdat_q;
  assign done_o       = done_q;
  assign done_err_o   = done_err_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values no matter which order the blocks are evaluated in.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic and beat qualification. An error ends the command
  // and takes priority over an ack in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    beat_ok   = 1'b0;
    last_beat = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = BUS;
      end
      BUS: begin
        abort     = wb_err_i;
        beat_ok   = wb_ack_i & wb_stb_o & ~wb_err_i;
        last_beat = beat_ok & (cnt_q == '0);
        if (abort || last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, address/beat counter and registered result pulses.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q         <= 1'b0;
      classic_q    <= 1'b0;
      word_q       <= '0;
      cnt_q        <= '0;
      bte_q        <= 2'b00;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      rdat_valid_q <= 1'b0;
      rdat_q       <= '0;
    end else begin
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      rdat_valid_q <= 1'b0;
      if (accept) begin
        we_q      <= cmd_we_i;
        classic_q <= (cmd_len_i == '0);
        word_q    <= cmd_adr_i[aw-1:2];
        cnt_q     <= cmd_len_i;
        bte_q     <= cmd_bte_i;
      end
      if (beat_ok) begin
        word_q <= next_word(word_q, bte_q);
        if (cnt_q != '0) cnt_q <= cnt_q - lw'(1);
        if (!we_q) begin
          rdat_valid_q <= 1'b1;
          rdat_q       <= wb_dat_i;
        end
      end
      if (last_beat || abort) begin
        done_q     <= 1'b1;
        done_err_q <= abort;
      end
    end
  end

endmodule

// File: tb/tb_ct_wb_burst_master.sv
// Testbench for ct_wb_burst_master. It includes a Wishbone slave with a
// 256-word memory, a write-data source, and a monitor that logs each
// accepted beat. Results are compared with an address/data model.
module tb_ct_wb_burst_master;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_ni = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [3:0]  cmd_len_i = '0;
  logic [1:0]  cmd_bte_i = '0;
  logic        wdat_valid_i = 1'b0, wdat_ready_o;
  logic [31:0] wdat_i = '0;
  logic        rdat_valid_o, done_o, done_err_o;
  logic [31:0] rdat_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  ct_wb_burst_master #(.dw(32), .aw(32), .lw(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
    .wdat_valid_i(wdat_valid_i), .wdat_i(wdat_i), .wdat_ready_o(wdat_ready_o),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o),
    .done_o(done_o), .done_err_o(done_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave / stream / monitor state ----------------
  logic [31:0] mem [256];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] log_adr[$];
  logic [2:0]  log_cti[$];
  logic [1:0]  log_bte[$];
  int  slave_waits = 0, wait_left = 0, err_at = -1, beat_n = 0;
  bit  rnd_ack = 0, gap_mode = 0, err_with_ack = 0;
  int  cyc_n = 0, cyc_cnt = 0, done_cnt = 0, done_cyc = 0, last_rv_cyc = -1, wcons = 0;
  int  hold_viol = 0, stb_viol = 0, rdy_viol = 0;
  logic done_err_v = 1'b0, done_rdy = 1'b0;
  logic prev_noack = 1'b0;
  logic [31:0] prev_adr;
  logic [2:0]  prev_cti;
  logic [1:0]  prev_bte;
  logic        prev_we;

  // Each cycle: drive the write stream at negedge, then the slave
  // response 1ns later, then sample everything 1ns after that.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      cyc_n++;
      if (wq.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
        wdat_valid_i = 1'b1;
        wdat_i       = wq[0];
      end else begin
        wdat_valid_i = 1'b0;
        wdat_i       = $urandom;
      end
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (wb_cyc_o && wb_stb_o) begin
        if (wait_left > 0) wait_left--;
        else if (rnd_ack && $urandom_range(0, 1) == 0) wait_left = 0;
        else begin
          if (beat_n == err_at) begin
            wb_err_i = 1'b1;
            wb_ack_i = err_with_ack;
          end else begin
            wb_ack_i = 1'b1;
          end
          if (!wb_we_o) wb_dat_i = mem[wb_adr_o[9:2]];
          wait_left = slave_waits;
        end
      end
      #1;
      if (wb_cyc_o) cyc_cnt++;
      if (wb_stb_o !== (wb_cyc_o & (~wb_we_o | wdat_valid_i))) stb_viol++;
      if (wdat_ready_o !== (wb_ack_i & wb_stb_o & wb_we_o & ~wb_err_i)) rdy_viol++;
      if (prev_noack && wb_cyc_o &&
          (wb_adr_o !== prev_adr || wb_cti_o !== prev_cti ||
           wb_bte_o !== prev_bte || wb_we_o !== prev_we)) hold_viol++;
      if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
        log_adr.push_back(wb_adr_o);
        log_cti.push_back(wb_cti_o);
        log_bte.push_back(wb_bte_o);
        if (wb_we_o) mem[wb_adr_o[9:2]] = wb_dat_o;
        beat_n++;
      end
      if (wdat_ready_o) begin
        if (wq.size() > 0) void'(wq.pop_front());
        wcons++;
      end
      if (rdat_valid_o) begin
        rq.push_back(rdat_o);
        last_rv_cyc = cyc_n;
      end
      if (done_o) begin
        done_cnt++;
        done_err_v = done_err_o;
        done_cyc   = cyc_n;
        done_rdy   = cmd_ready_o;
      end
      prev_noack = wb_cyc_o & ~(wb_ack_i & wb_stb_o) & ~wb_err_i;
      prev_adr   = wb_adr_o;
      prev_cti   = wb_cti_o;
      prev_bte   = wb_bte_o;
      prev_we    = wb_we_o;
    end
  end

  // Reference address of beat i, computed from the burst rules.
  function automatic logic [31:0] exp_adr(input logic [31:0] a, input int i, input logic [1:0] bte);
    int unsigned w, n;
    w = a >> 2;
    case (bte)
      2'b01:   n = 4;
      2'b10:   n = 8;
      2'b11:   n = 16;
      default: n = 0;
    endcase
    if (n == 0) return (w + i) << 2;
    return ((w - (w % n)) + ((w + i) % n)) << 2;
  endfunction

  task automatic clear_logs();
    wq.delete(); rq.delete(); log_adr.delete(); log_cti.delete(); log_bte.delete();
    beat_n = 0; cyc_cnt = 0; done_cnt = 0; last_rv_cyc = -1; wcons = 0;
    hold_viol = 0; stb_viol = 0; rdy_viol = 0; done_err_v = 1'b0; done_rdy = 1'b0;
  endtask

  // Offers a command. It must be called just after a negedge.
  task automatic issue_cmd(input logic we, input logic [31:0] adr,
                           input logic [3:0] len, input logic [1:0] bte);
    check("cmd_ready before cmd", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_len_i   = len;
    cmd_bte_i   = bte;
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                         input logic [1:0] bte, input int e_at, input int waits,
                         input bit rnd, input bit gaps);
    logic [31:0] snap [256];
    logic [31:0] model [256];
    logic [31:0] wdata[$];
    logic [31:0] ea, d;
    logic [2:0]  ec;
    int          total, exp_beats, n;
    logic        exp_err;
    total     = int'(len) + 1;
    exp_err   = (e_at >= 0 && e_at < total);
    exp_beats = exp_err ? e_at : total;
    @(negedge wb_clk_i);
    clear_logs();
    err_at = e_at; slave_waits = waits; wait_left = waits;
    rnd_ack = rnd; gap_mode = gaps; err_with_ack = 1'($urandom_range(0, 1));
    if (we) begin
      for (int i = 0; i < total; i++) begin
        d = $urandom;
        wq.push_back(d);
        wdata.push_back(d);
      end
    end
    snap = mem;
    issue_cmd(we, adr, len, bte);
    for (int t = 0; t < 600 && done_cnt == 0; t++) @(posedge wb_clk_i);
    repeat (3) @(posedge wb_clk_i);
    #3;
    check("done pulse count", done_cnt, 1);
    check("done_err", done_err_v, exp_err);
    check("cmd_ready with done", done_rdy, 1'b1);
    check("beats accepted", log_adr.size(), exp_beats);
    n = (log_adr.size() < exp_beats) ? log_adr.size() : exp_beats;
    for (int i = 0; i < n; i++) begin
      ea = exp_adr(adr, i, bte);
      ec = (len == 0) ? 3'b000 : ((i < int'(len)) ? 3'b010 : 3'b111);
      check($sformatf("adr beat %0d", i), log_adr[i], ea);
      check($sformatf("cti beat %0d", i), log_cti[i], ec);
      check($sformatf("bte beat %0d", i), log_bte[i], bte);
    end
    check("outputs held in wait", hold_viol, 0);
    check("stb rule", stb_viol, 0);
    check("wdat_ready rule", rdy_viol, 0);
    if (!we) begin
      check("rdat_valid count", rq.size(), exp_beats);
      n = (rq.size() < exp_beats) ? rq.size() : exp_beats;
      for (int i = 0; i < n; i++) begin
        ea = exp_adr(adr, i, bte);
        check($sformatf("rdat beat %0d", i), rq[i], snap[ea[9:2]]);
      end
      if (!exp_err) check("done with last rdat", done_cyc, last_rv_cyc);
    end else begin
      check("wdat consumed", wcons, exp_beats);
      model = snap;
      for (int i = 0; i < exp_beats; i++) begin
        ea = exp_adr(adr, i, bte);
        model[ea[9:2]] = wdata[i];
      end
      for (int i = 0; i < total; i++) begin
        ea = exp_adr(adr, i, bte);
        check($sformatf("mem word 0x%0h", ea), mem[ea[9:2]], model[ea[9:2]]);
      end
    end
    if (!rnd && !gaps)
      check("cyc cycles", cyc_cnt, exp_err ? (e_at + 1) * (waits + 1) : total * (waits + 1));
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  len;
    logic [1:0]  bte;
    int          err_at;
    int          exp_beats;
    logic        exp_err;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    vecs[0] = '{1'b0, 32'h100, 4'd0,  2'b00, -1, 1,  1'b0, 32'h100, 32'h100};
    vecs[1] = '{1'b1, 32'h040, 4'd7,  2'b00, -1, 8,  1'b0, 32'h040, 32'h05C};
    vecs[2] = '{1'b0, 32'h018, 4'd3,  2'b01, -1, 4,  1'b0, 32'h018, 32'h014};
    vecs[3] = '{1'b0, 32'h200, 4'd7,  2'b00,  2, 2,  1'b1, 32'h200, 32'h204};
    vecs[4] = '{1'b1, 32'h03C, 4'd7,  2'b10, -1, 8,  1'b0, 32'h03C, 32'h038};
    vecs[5] = '{1'b1, 32'h080, 4'd15, 2'b11,  0, 0,  1'b1, 32'h000, 32'h000};
    vecs[6] = '{1'b0, 32'h3F0, 4'd15, 2'b11, -1, 16, 1'b0, 32'h3F0, 32'h3EC};

    // reset state
    #2 wb_rst_ni = 1'b0;
    #2;
    check("reset cyc", wb_cyc_o, 1'b0);
    check("reset stb", wb_stb_o, 1'b0);
    check("reset we", wb_we_o, 1'b0);
    check("reset done", done_o, 1'b0);
    check("reset done_err", done_err_o, 1'b0);
    check("reset rdat_valid", rdat_valid_o, 1'b0);
    check("reset cti", wb_cti_o, 3'b000);
    check("reset bte", wb_bte_o, 2'b00);
    check("reset adr", wb_adr_o, 32'h0);
    check("reset cmd_ready", cmd_ready_o, 1'b1);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    // table-driven directed commands against a one-wait-state slave
    foreach (vecs[k]) begin
      run_cmd(vecs[k].we, vecs[k].adr, vecs[k].len, vecs[k].bte, vecs[k].err_at, 1, 1'b0, 1'b0);
      check($sformatf("vec %0d beats", k), log_adr.size(), vecs[k].exp_beats);
      check($sformatf("vec %0d done_err", k), done_err_v, vecs[k].exp_err);
      if (vecs[k].exp_beats > 0 && log_adr.size() > 0) begin
        check($sformatf("vec %0d first adr", k), log_adr[0], vecs[k].exp_first);
        check($sformatf("vec %0d last adr", k), log_adr[log_adr.size()-1], vecs[k].exp_last);
      end
    end

    // 16-beat write with stream gaps and random ack negation
    run_cmd(1'b1, 32'h300, 4'd15, 2'b00, -1, 0, 1'b1, 1'b1);

    // reset in the middle of a read burst
    @(negedge wb_clk_i);
    clear_logs();
    err_at = -1; slave_waits = 1; wait_left = 1; rnd_ack = 0; gap_mode = 0;
    issue_cmd(1'b0, 32'h180, 4'd15, 2'b00);
    for (int t = 0; t < 100 && beat_n < 3; t++) @(posedge wb_clk_i);
    check("beats before reset", beat_n >= 3, 1'b1);
    #3 wb_rst_ni = 1'b0;
    #1;
    check("cyc drops on reset", wb_cyc_o, 1'b0);
    check("stb drops on reset", wb_stb_o, 1'b0);
    check("ready during reset", cmd_ready_o, 1'b1);
    repeat (3) @(posedge wb_clk_i);
    #3;
    check("no done after reset", done_cnt, 0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    run_cmd(1'b0, 32'h180, 4'd3, 2'b00, -1, 0, 1'b0, 1'b0);

    // randomized commands
    for (int r = 0; r < 24; r++) begin
      logic        rwe;
      logic [31:0] radr;
      logic [3:0]  rlen;
      logic [1:0]  rbte;
      int          re;
      rwe  = 1'($urandom_range(0, 1));
      radr = $urandom_range(0, 1023);
      rlen = 4'($urandom_range(0, 15));
      rbte = 2'($urandom_range(0, 3));
      re   = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, int'(rlen)));
      run_cmd(rwe, radr, rlen, rbte, re, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
